// File: rtl/hazard_ctrl_unit.sv
// Decode-stage hazard controller: load-use stall sequencing, taken-branch flush
// sequencing, and saturating stall/flush event counters for the debug unit.
module hazard_ctrl_unit #(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1,
  parameter int CNT_W               = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [31:0]      instr_id,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             stop,
  output logic             flush,
  output logic [1:0]       state_dbg,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    BAD   = 2'd3
  } state_t;

  // Reload values count the cycles remaining after the one that enters the state.
  localparam int STALL_RELOAD = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0;
  localparam int FLUSH_RELOAD = (BRANCH_FLUSH_CYCLES > 1) ? BRANCH_FLUSH_CYCLES - 2 : 0;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       uses_rt, hz;
  logic       unused_instr_bits;

  assign op                = instr_id[31:26];
  assign rs                = instr_id[25:21];
  assign rt                = instr_id[20:16];
  assign unused_instr_bits = ^instr_id[15:0];

  assign uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
  assign hz      = ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

  assign state_dbg = rst ? 2'd0 : state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    stop       = 1'b0;
    flush      = 1'b0;
    if (rst) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (!ena) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (branch_taken) begin
      flush = 1'b1;
      stop  = 1'b1;
      if (BRANCH_FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = 8'(FLUSH_RELOAD);
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hz) begin
            stop       = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = 8'(STALL_RELOAD);
            end
          end
        end
        STALL: begin
          stop       = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 8'd1;
        end
        FLUSH: begin
          flush = 1'b1;
          stop  = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 8'd1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stop && !flush && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one default instance (a) and one with
// multi-cycle stall/flush and a narrow counter (b) to reach saturation quickly.
module tb_hazard_ctrl_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_ena, a_mr, a_br;
  logic [31:0] a_instr;
  logic [4:0]  a_ex_rt;
  logic        a_pc, a_ifid, a_stop, a_flush;
  logic [1:0]  a_sd;
  logic [15:0] a_sc, a_fc;

  logic        b_rst, b_ena, b_mr, b_br;
  logic [31:0] b_instr;
  logic [4:0]  b_ex_rt;
  logic        b_pc, b_ifid, b_stop, b_flush;
  logic [1:0]  b_sd;
  logic [3:0]  b_sc, b_fc;

  int checks = 0;
  int errors = 0;

  hazard_ctrl_unit dut_a (
    .clk(clk), .rst(a_rst), .ena(a_ena), .instr_id(a_instr), .ex_mem_read(a_mr),
    .ex_rt(a_ex_rt), .branch_taken(a_br), .pc_write(a_pc), .ifid_write(a_ifid),
    .stop(a_stop), .flush(a_flush), .state_dbg(a_sd), .stall_count(a_sc),
    .flush_count(a_fc)
  );

  hazard_ctrl_unit #(
    .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(b_rst), .ena(b_ena), .instr_id(b_instr), .ex_mem_read(b_mr),
    .ex_rt(b_ex_rt), .branch_taken(b_br), .pc_write(b_pc), .ifid_write(b_ifid),
    .stop(b_stop), .flush(b_flush), .state_dbg(b_sd), .stall_count(b_sc),
    .flush_count(b_fc)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return {op, rs, rt, 16'h0820};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic out_a(input string tag, input logic pc, input logic ifid,
                       input logic st, input logic fl, input logic [1:0] sd);
    check({tag, ".pc_write"},   32'(a_pc),    32'(pc));
    check({tag, ".ifid_write"}, 32'(a_ifid),  32'(ifid));
    check({tag, ".stop"},       32'(a_stop),  32'(st));
    check({tag, ".flush"},      32'(a_flush), 32'(fl));
    check({tag, ".state_dbg"},  32'(a_sd),    32'(sd));
  endtask

  task automatic out_b(input string tag, input logic pc, input logic ifid,
                       input logic st, input logic fl, input logic [1:0] sd);
    check({tag, ".pc_write"},   32'(b_pc),    32'(pc));
    check({tag, ".ifid_write"}, 32'(b_ifid),  32'(ifid));
    check({tag, ".stop"},       32'(b_stop),  32'(st));
    check({tag, ".flush"},      32'(b_flush), 32'(fl));
    check({tag, ".state_dbg"},  32'(b_sd),    32'(sd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_ena = 1'b1; a_br = 1'b0;
    a_mr = 1'b1; a_ex_rt = 5'd5; a_instr = mk(6'h00, 5'd5, 5'd2);
    b_rst = 1'b1; b_ena = 1'b1; b_br = 1'b0; b_mr = 1'b0; b_ex_rt = 5'd0;
    b_instr = 32'h0;
    #1;
    // Reset dominates a live hazard.
    out_a("a_in_reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    check("a_reset_stall_count", 32'(a_sc), 32'd0);
    check("a_reset_flush_count", 32'(a_fc), 32'd0);
    // Load-use: add r1,r5,r2 behind lw r5.
    out_a("a_loaduse", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    a_mr = 1'b0;
    #1;
    check("a_stall_count_1", 32'(a_sc), 32'd1);
    out_a("a_after_bubble", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

    // ex_rt == 0 never hazards.
    a_mr = 1'b1; a_ex_rt = 5'd0; a_instr = mk(6'h00, 5'd0, 5'd2);
    #1;
    out_a("a_exrt_zero", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    // lw does not read rt.
    a_ex_rt = 5'd7; a_instr = mk(6'h23, 5'd3, 5'd7);
    #1;
    out_a("a_lw_rt_match", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    // sw does read rt.
    a_instr = mk(6'h2B, 5'd3, 5'd7);
    #1;
    out_a("a_sw_rt_match", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    check("a_stall_count_2", 32'(a_sc), 32'd2);

    // Branch beats hazard.
    a_ex_rt = 5'd5; a_instr = mk(6'h00, 5'd5, 5'd2); a_br = 1'b1;
    #1;
    out_a("a_branch_hz", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
    tick();
    a_br = 1'b0; a_mr = 1'b0;
    #1;
    check("a_branch_stall_count", 32'(a_sc), 32'd2);
    check("a_branch_flush_count", 32'(a_fc), 32'd1);
    out_a("a_after_branch", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

    // Freeze with a hazard present: nothing counts.
    a_ena = 1'b0; a_mr = 1'b1;
    #1;
    out_a("a_freeze", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    check("a_freeze_stall_count", 32'(a_sc), 32'd2);
    a_ena = 1'b1; a_mr = 1'b0;

    // b: three-cycle load-use bubble, state 0,1,1,0.
    b_mr = 1'b1; b_ex_rt = 5'd5; b_instr = mk(6'h00, 5'd5, 5'd2);
    #1;
    out_b("b_hz_c0", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    b_mr = 1'b0;
    #1;
    out_b("b_hz_c1", 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    out_b("b_hz_c2", 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    out_b("b_hz_done", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    check("b_stall_count_3", 32'(b_sc), 32'd3);

    // Freeze for four cycles mid-STALL, then resume.
    b_mr = 1'b1;
    #1;
    tick();
    b_mr = 1'b0; b_ena = 1'b0;
    #1;
    out_b("b_freeze", 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    repeat (4) tick();
    check("b_freeze_state", 32'(b_sd), 32'd1);
    check("b_freeze_stall_count", 32'(b_sc), 32'd4);
    b_ena = 1'b1;
    #1;
    out_b("b_resume_c1", 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    out_b("b_resume_c2", 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    out_b("b_resume_done", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    check("b_stall_count_6", 32'(b_sc), 32'd6);

    // Branch mid-STALL: two-cycle flush, remaining stall dropped.
    b_mr = 1'b1;
    #1;
    tick();
    b_mr = 1'b0; b_br = 1'b1;
    #1;
    out_b("b_branch_in_stall", 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
    tick();
    b_br = 1'b0;
    #1;
    check("b_branch_stall_count", 32'(b_sc), 32'd7);
    out_b("b_flush_c2", 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
    tick();
    out_b("b_flush_done", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    check("b_flush_count_2", 32'(b_fc), 32'd2);
    check("b_stall_count_7", 32'(b_sc), 32'd7);

    // Reset mid-FLUSH.
    b_br = 1'b1;
    #1;
    tick();
    b_br = 1'b0; b_rst = 1'b1;
    #1;
    out_b("b_reset_in_flush", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    b_rst = 1'b0;
    #1;
    out_b("b_after_reset", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    check("b_reset_stall_count", 32'(b_sc), 32'd0);
    check("b_reset_flush_count", 32'(b_fc), 32'd0);

    // Continuous hazard: stop every cycle, counter saturates at 4'hF.
    b_mr = 1'b1; b_ex_rt = 5'd5;
    #1;
    repeat (20) tick();
    check("b_sat_stall_count", 32'(b_sc), 32'hF);
    check("b_sat_stop", 32'(b_stop), 32'd1);
    tick();
    check("b_sat_hold", 32'(b_sc), 32'hF);
    b_mr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
